svdb_csr_bank: RTL and testbench

//  Parametrised control/status register bank: the synthesizable counterpart of the

---
 rtl/svdb_csr_pkg.sv | 28 ++
 rtl/svdb_csr_reg.sv | 54 +++++
 rtl/svdb_csr_bank.sv | 143 ++++++++++++++
 tb/tb_svdb_csr_bank.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/svdb_csr_pkg.sv
`default_nettype none
// ============================================================================
// svdb_csr_pkg : shared types and byte-merge helper for the CSR bank
// Rev 1.0
// ============================================================================
package svdb_csr_pkg;

    typedef enum logic [1:0] {
        CSR_RW  = 2'd0,
        CSR_RO  = 2'd1,
        CSR_W1C = 2'd2,
        CSR_WO1 = 2'd3
    } csr_access_e;

    typedef enum logic [0:0] {
        CSR_IDLE = 1'b0,
        CSR_RESP = 1'b1
    } csr_state_e;

    // One byte lane of a strobed write: take the new byte only when enabled.
    function automatic logic [7:0] apply_wstrb(input logic [7:0] old_byte,
                                               input logic [7:0] new_byte,
                                               input logic       en);
        return en ? new_byte : old_byte;
    endfunction

endpackage
`default_nettype wire

// File: rtl/svdb_csr_reg.sv
`default_nettype none
// ============================================================================
// svdb_csr_reg : one CSR with a fixed access policy and reset value
// Rev 1.0
// ============================================================================
module svdb_csr_reg
    import svdb_csr_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter csr_access_e       ACCESS    = CSR_RW,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                wr_en_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    input  logic [DATA_W-1:0]   hw_set_i,
    output logic [DATA_W-1:0]   q_o
);

    localparam int c_NBYTES = DATA_W / 8;

    logic [DATA_W-1:0] r_q;
    logic [DATA_W-1:0] w_merged;
    logic [DATA_W-1:0] w_clr;

    always_comb begin
        w_merged = r_q;
        w_clr    = '0;
        for (int b = 0; b < c_NBYTES; b++) begin
            w_merged[8*b +: 8] = apply_wstrb(r_q[8*b +: 8], wdata_i[8*b +: 8], wstrb_i[b]);
            w_clr[8*b +: 8]    = apply_wstrb(8'h00, wdata_i[8*b +: 8], wr_en_i & wstrb_i[b]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_q <= RESET_VAL;
        end else begin
            case (ACCESS)
                CSR_RO:  r_q <= hw_set_i;
                // Set is OR'ed after the clear so a same-cycle set wins.
                CSR_W1C: r_q <= (r_q & ~w_clr) | hw_set_i;
                CSR_WO1: if (wr_en_i) r_q <= {w_merged[DATA_W-1:1], w_merged[0] | r_q[0]};
                default: if (wr_en_i) r_q <= w_merged;
            endcase
        end
    end

    assign q_o = r_q;

endmodule
`default_nettype wire

// File: rtl/svdb_csr_bank.sv
`default_nettype none
// ============================================================================
// svdb_csr_bank : valid/ready CSR bank with access policy, W1C capture and lock
// Rev 1.0
// ============================================================================
module svdb_csr_bank
    import svdb_csr_pkg::*;
#(
    parameter int                         NUM_REGS    = 4,
    parameter int                         DATA_W      = 32,
    parameter int                         ADDR_W      = 8,
    parameter int                         ADDR_STRIDE = 4,
    parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALS  = '0,
    parameter logic [NUM_REGS*2-1:0]      ACCESS      = '0,
    parameter int                         LOCK_IDX    = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic                       req_write_i,
    input  logic [ADDR_W-1:0]          req_addr_i,
    input  logic [DATA_W-1:0]          req_wdata_i,
    input  logic [DATA_W/8-1:0]        req_wstrb_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [DATA_W-1:0]          rsp_rdata_o,
    output logic                       rsp_err_o,
    input  logic [NUM_REGS*DATA_W-1:0] hw_set_i,
    output logic [NUM_REGS*DATA_W-1:0] regs_o,
    output logic                       locked_o
);

    localparam int c_STRIDE_SH = $clog2(ADDR_STRIDE);
    localparam int c_IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    csr_state_e          r_state;
    logic                r_req_ready;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;

    logic [DATA_W-1:0]   w_regs   [NUM_REGS];
    csr_access_e         w_access [NUM_REGS];
    logic [NUM_REGS-1:0] w_wr_en;
    logic [ADDR_W-1:0]   w_idx;
    logic [ADDR_W-1:0]   w_off;
    logic [c_IDX_W-1:0]  w_sel;
    logic                w_in_range;
    logic                w_accept;
    logic                w_err;
    logic [DATA_W-1:0]   w_rdata;

    assign w_accept   = req_valid_i & r_req_ready;
    assign w_idx      = req_addr_i >> c_STRIDE_SH;
    assign w_off      = req_addr_i & ADDR_W'(ADDR_STRIDE - 1);
    assign w_sel      = w_idx[c_IDX_W-1:0];
    assign w_in_range = (w_off == '0) && (int'(w_idx) < NUM_REGS);

    always_comb begin
        w_err = !w_in_range;
        if (w_in_range && req_write_i) begin
            if (w_access[w_sel] == CSR_RO)
                w_err = 1'b1;
            // Lock only freezes plain RW registers; W1C clears stay allowed.
            if (w_access[w_sel] == CSR_RW && locked_o)
                w_err = 1'b1;
        end
        w_rdata = (w_err || req_write_i) ? '0 : w_regs[w_sel];
    end

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
            assign w_access[i] = csr_access_e'(ACCESS[2*i +: 2]);
            assign w_wr_en[i]  = w_accept && req_write_i && !w_err && (int'(w_sel) == i);

            svdb_csr_reg #(
                .DATA_W    (DATA_W),
                .ACCESS    (csr_access_e'(ACCESS[2*i +: 2])),
                .RESET_VAL (RESET_VALS[DATA_W*i +: DATA_W])
            ) u_reg (
                .clk_i    (clk_i),
                .rst_ni   (rst_ni),
                .wr_en_i  (w_wr_en[i]),
                .wdata_i  (req_wdata_i),
                .wstrb_i  (req_wstrb_i),
                .hw_set_i (hw_set_i[DATA_W*i +: DATA_W]),
                .q_o      (w_regs[i])
            );

            assign regs_o[DATA_W*i +: DATA_W] = w_regs[i];
        end

        if (LOCK_IDX < NUM_REGS) begin : g_lock_on
            assign locked_o = w_regs[LOCK_IDX][0];
        end else begin : g_lock_off
            assign locked_o = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= CSR_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                CSR_IDLE: begin
                    if (w_accept) begin
                        r_state     <= CSR_RESP;
                        r_req_ready <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= w_rdata;
                        r_rsp_err   <= w_err;
                    end
                end
                CSR_RESP: begin
                    if (rsp_ready_i) begin
                        r_state     <= CSR_IDLE;
                        r_req_ready <= 1'b1;
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= CSR_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o = r_req_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_err_o   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_svdb_csr_bank.sv
`default_nettype none
// ============================================================================
// tb_svdb_csr_bank : directed scoreboard bench for svdb_csr_bank
// Rev 1.0
// ============================================================================
module tb_svdb_csr_bank;

    localparam int         c_N   = 4;
    localparam int         c_W   = 32;
    localparam logic [127:0] c_RST = {32'h0, 32'h0, 32'h0000_00A5, 32'h0};
    localparam logic [7:0]   c_ACC = {2'd3, 2'd0, 2'd0, 2'd2};

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_write = 1'b0;
    logic [7:0]       req_addr = '0;
    logic [31:0]      req_wdata = '0;
    logic [3:0]       req_wstrb = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [31:0]      rsp_rdata;
    logic             rsp_err;
    logic [127:0]     hw_set = '0;
    logic [127:0]     regs;
    logic             locked;

    int               n_cmp = 0;
    int               n_bad = 0;
    logic [32:0]      exp_q[$];
    logic [32:0]      e;
    logic [31:0]      held;

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1);
    end

    svdb_csr_bank #(
        .NUM_REGS    (c_N),
        .DATA_W      (c_W),
        .ADDR_W      (8),
        .ADDR_STRIDE (4),
        .RESET_VALS  (c_RST),
        .ACCESS      (c_ACC),
        .LOCK_IDX    (3)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_wstrb_i (req_wstrb),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .hw_set_i    (hw_set),
        .regs_o      (regs),
        .locked_o    (locked)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request with rsp_ready high; hw0 drives reg0's hw_set only on the accept edge.
    task automatic do_req(input string tag, input logic wr, input logic [7:0] a,
                          input logic [31:0] d, input logic [3:0] s, input logic [31:0] hw0,
                          input logic [31:0] er, input logic ee);
        logic [32:0] x;
        int          waited;
        waited = 0;
        exp_q.push_back({er, ee});
        while (req_ready !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        chk({tag, "_ready"}, 128'(req_ready), 128'(1'b1));
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s;
        hw_set[31:0] = hw0;
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'b0; req_wdata = '0; req_wstrb = '0;
        hw_set = '0;
        @(negedge clk);
        chk({tag, "_valid"}, 128'(rsp_valid), 128'(1'b1));
        x = exp_q.pop_front();
        chk({tag, "_rdata"}, 128'(rsp_rdata), 128'(x[32:1]));
        chk({tag, "_err"},   128'(rsp_err),   128'(x[0]));
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready",  128'(req_ready), 128'(1'b1));
        chk("rst_valid",  128'(rsp_valid), 128'(1'b0));
        chk("rst_rdata",  128'(rsp_rdata), 128'(0));
        chk("rst_err",    128'(rsp_err),   128'(1'b0));
        chk("rst_regs",   regs,            c_RST);
        chk("rst_locked", 128'(locked),    128'(1'b0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_req("rd_reg1_rst", 1'b0, 8'h04, 32'h0, 4'h0, 32'h0, 32'h0000_00A5, 1'b0);

        do_req("wr_reg1_strb", 1'b1, 8'h04, 32'h1234_5678, 4'b0011, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        chk("regs_reg1", 128'(regs[63:32]), 128'(32'h0000_5678));
        do_req("rd_reg1_strb", 1'b0, 8'h04, 32'h0, 4'h0, 32'h0, 32'h0000_5678, 1'b0);

        // W1C capture, clear with concurrent set, then plain clear
        hw_set[31:0] = 32'h5;
        @(posedge clk); #1;
        hw_set = '0;
        do_req("w1c_clr_set", 1'b1, 8'h00, 32'h1, 4'hF, 32'h1, 32'h0, 1'b0);
        do_req("w1c_rd_set", 1'b0, 8'h00, 32'h0, 4'h0, 32'h0, 32'h5, 1'b0);
        do_req("w1c_clr", 1'b1, 8'h00, 32'h5, 4'hF, 32'h0, 32'h0, 1'b0);
        do_req("w1c_rd_clr", 1'b0, 8'h00, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0);

        // Lock
        do_req("wr_reg2", 1'b1, 8'h08, 32'hCAFE_BABE, 4'hF, 32'h0, 32'h0, 1'b0);
        do_req("wr_lock", 1'b1, 8'h0C, 32'h1, 4'hF, 32'h0, 32'h0, 1'b0);
        chk("locked_set", 128'(locked), 128'(1'b1));
        do_req("wr_reg2_locked", 1'b1, 8'h08, 32'h1111_1111, 4'hF, 32'h0, 32'h0, 1'b1);
        do_req("rd_reg2_locked", 1'b0, 8'h08, 32'h0, 4'h0, 32'h0, 32'hCAFE_BABE, 1'b0);
        do_req("wr_lock_zero", 1'b1, 8'h0C, 32'h0, 4'hF, 32'h0, 32'h0, 1'b0);
        chk("locked_sticky", 128'(locked), 128'(1'b1));
        hw_set[31:0] = 32'h8;
        @(posedge clk); #1;
        hw_set = '0;
        do_req("w1c_clr_locked", 1'b1, 8'h00, 32'h8, 4'h1, 32'h0, 32'h0, 1'b0);
        do_req("w1c_rd_locked", 1'b0, 8'h00, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0);

        // Decode errors
        do_req("rd_unaligned", 1'b0, 8'h02, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1);
        do_req("rd_oor", 1'b0, 8'h10, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1);

        // Backpressure then async reset while in RESP
        rsp_ready = 1'b0;
        exp_q.push_back({32'hCAFE_BABE, 1'b0});
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h08;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        e = exp_q.pop_front();
        chk("bp_rdata", 128'(rsp_rdata), 128'(e[32:1]));
        chk("bp_err",   128'(rsp_err),   128'(e[0]));
        held = rsp_rdata;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", 128'(rsp_valid), 128'(1'b1));
            chk("bp_ready", 128'(req_ready), 128'(1'b0));
            chk("bp_hold",  128'(rsp_rdata), 128'(held));
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid",  128'(rsp_valid), 128'(1'b0));
        chk("arst_ready",  128'(req_ready), 128'(1'b1));
        chk("arst_regs",   regs,            c_RST);
        chk("arst_locked", 128'(locked),    128'(1'b0));
        rsp_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_req("rd_reg1_after", 1'b0, 8'h04, 32'h0, 4'h0, 32'h0, 32'h0000_00A5, 1'b0);
        do_req("wr_reg2_unlocked", 1'b1, 8'h08, 32'h0000_00FF, 4'h1, 32'h0, 32'h0, 1'b0);
        chk("q_empty", 128'(exp_q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
